motor_pwm_driver: RTL and testbench

- Downstream stage of the current-control loop. Consumes the 12-bit unsigned motor drive command and produces complementary half-bridge gate signals.
- The output carrier is a fixed-period PWM with dead-time insertion, per-period duty slew limiting and a latched fault shutdown.
- Sits between the current-control output and the gate-driver pins.

---
 rtl/motor_pkg.sv | 24 ++
 rtl/pwm_slew_limiter.sv | 82 ++++++++
 rtl/motor_pwm_driver.sv | 198 +++++++++++++++++++
 tb/tb_motor_pwm_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// ---------------------------------------------------------------------------
// motor_pkg
// Shared types and default sizing for the motor PWM gate driver.
//   pwm_state_t       : half-bridge sequencing states
//   PWM_CNT_WIDTH     : PWM counter width (period = 2**width clocks)
//   PWM_DEADTIME_DEF  : both-gates-low cycles on every gate handover
//   PWM_SLEW_DEF      : maximum applied-duty change per PWM period
// ---------------------------------------------------------------------------
package motor_pkg;

    localparam int PWM_CNT_WIDTH    = 12;
    localparam int PWM_DEADTIME_DEF = 4;
    localparam int PWM_SLEW_DEF     = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN_HI  = 3'd1,
        DEAD_HL = 3'd2,
        RUN_LO  = 3'd3,
        DEAD_LH = 3'd4,
        FAULT   = 3'd5
    } pwm_state_t;

endpackage

// File: rtl/pwm_slew_limiter.sv
// ---------------------------------------------------------------------------
// pwm_slew_limiter
// Holds the duty currently in effect and moves it toward the commanded
// target by at most SLEW_STEP counts per update strobe.
//   clk_i       : clock
//   reset_i     : synchronous active-high reset, clears the applied duty
//   clear_i     : forces the applied duty to zero (driver idle)
//   update_i    : one-cycle strobe on the PWM counter wrap
//   target_i    : commanded duty sampled on the strobe
//   duty_o      : applied duty (registered)
//   duty_next_o : value duty_o takes at the coming edge
// ---------------------------------------------------------------------------
module pwm_slew_limiter
    import motor_pkg::*;
#(
    parameter int CNT_WIDTH = PWM_CNT_WIDTH,
    parameter int SLEW_STEP = PWM_SLEW_DEF
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 update_i,
    input  logic [CNT_WIDTH-1:0] target_i,
    output logic [CNT_WIDTH-1:0] duty_o,
    output logic [CNT_WIDTH-1:0] duty_next_o
);

    localparam int MAX_VAL  = (2 ** CNT_WIDTH) - 1;
    // A step larger than full scale behaves exactly like full scale.
    localparam int STEP_SAT = (SLEW_STEP > MAX_VAL) ? MAX_VAL : SLEW_STEP;
    localparam logic [CNT_WIDTH:0] STEP_W = (CNT_WIDTH + 1)'(STEP_SAT);
    localparam logic [CNT_WIDTH:0] MAX_W  = (CNT_WIDTH + 1)'(MAX_VAL);

    logic [CNT_WIDTH-1:0] duty_q;
    logic [CNT_WIDTH-1:0] duty_d;
    logic [CNT_WIDTH:0]   tgt_s;
    logic [CNT_WIDTH:0]   cur_s;
    logic [CNT_WIDTH:0]   diff_s;
    logic [CNT_WIDTH:0]   step_s;
    logic [CNT_WIDTH:0]   sum_s;
    logic [CNT_WIDTH-1:0] stepped_s;

    // Bounded step toward the target in one extra bit, then clamp to range.
    always_comb begin
        tgt_s = {1'b0, target_i};
        cur_s = {1'b0, duty_q};
        if (tgt_s > cur_s) begin
            diff_s = tgt_s - cur_s;
            step_s = (diff_s > STEP_W) ? STEP_W : diff_s;
            sum_s  = cur_s + step_s;
        end else begin
            diff_s = cur_s - tgt_s;
            step_s = (diff_s > STEP_W) ? STEP_W : diff_s;
            sum_s  = cur_s - step_s;
        end
        if (sum_s > MAX_W) begin
            stepped_s = MAX_W[CNT_WIDTH-1:0];
        end else begin
            stepped_s = sum_s[CNT_WIDTH-1:0];
        end
        if (clear_i) begin
            duty_d = {CNT_WIDTH{1'b0}};
        end else if (update_i) begin
            duty_d = stepped_s;
        end else begin
            duty_d = duty_q;
        end
    end

    // Applied duty register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            duty_q <= {CNT_WIDTH{1'b0}};
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty_o      = duty_q;
    assign duty_next_o = duty_d;

endmodule

// File: rtl/motor_pwm_driver.sv
// ---------------------------------------------------------------------------
// motor_pwm_driver
// Fixed-period PWM for one half bridge with dead-time insertion, per-period
// duty slew limiting and latched fault shutdown.
//   c20k          : system clock, rising edge
//   reset         : synchronous active-high reset
//   enable        : run request, low forces idle
//   fault         : overcurrent / driver fault, sampled every cycle
//   duty_in       : commanded duty (0 = fully low side)
//   gate_hi       : high-side gate drive (registered)
//   gate_lo       : low-side gate drive (registered)
//   period_start  : one-cycle pulse while the counter sits at 0 after a wrap
//   duty_applied  : post-slew duty in effect
//   fault_latched : sticky fault flag
// ---------------------------------------------------------------------------
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int CNT_WIDTH = PWM_CNT_WIDTH,
    parameter int DEADTIME  = PWM_DEADTIME_DEF,
    parameter int SLEW_STEP = PWM_SLEW_DEF
) (
    input  logic                 c20k,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fault,
    input  logic [CNT_WIDTH-1:0] duty_in,
    output logic                 gate_hi,
    output logic                 gate_lo,
    output logic                 period_start,
    output logic [CNT_WIDTH-1:0] duty_applied,
    output logic                 fault_latched
);

    localparam int DW = (DEADTIME > 2) ? $clog2(DEADTIME) : 1;
    localparam logic [DW-1:0]        DEAD_LOAD = DW'(DEADTIME - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]   FULL_W    = (CNT_WIDTH + 1)'(2 ** CNT_WIDTH);
    localparam logic [CNT_WIDTH:0]   DT_W      = (CNT_WIDTH + 1)'(DEADTIME);
    localparam logic [CNT_WIDTH:0]   HI_THR_W  = FULL_W - DT_W;

    pwm_state_t           state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [DW-1:0]        dead_q;
    logic                 gate_hi_q;
    logic                 gate_lo_q;
    logic                 period_start_q;
    logic                 fault_latched_q;

    logic                 running_s;
    logic                 wrap_s;
    logic                 update_s;
    logic                 clear_s;
    logic [CNT_WIDTH-1:0] cnt_d_s;
    logic [CNT_WIDTH-1:0] duty_q_s;
    logic [CNT_WIDTH-1:0] duty_next_s;
    logic [CNT_WIDTH:0]   duty_ext_s;
    logic [CNT_WIDTH:0]   d_eff_s;
    logic                 want_hi_s;

    // Counter runs only in RUN/DEAD states; the wrap strobe drives the duty update.
    always_comb begin
        case (state_q)
            RUN_HI, DEAD_HL, RUN_LO, DEAD_LH: running_s = 1'b1;
            default:                          running_s = 1'b0;
        endcase
        wrap_s   = running_s && (cnt_q == CNT_MAX);
        update_s = wrap_s && enable && !fault;
        clear_s  = (state_q == IDLE);
        if (state_q == IDLE) begin
            cnt_d_s = {CNT_WIDTH{1'b0}};
        end else if (running_s) begin
            cnt_d_s = cnt_q + CNT_ONE;
        end else begin
            cnt_d_s = cnt_q;
        end
    end

    pwm_slew_limiter #(
        .CNT_WIDTH (CNT_WIDTH),
        .SLEW_STEP (SLEW_STEP)
    ) u_slew (
        .clk_i       (c20k),
        .reset_i     (reset),
        .clear_i     (clear_s),
        .update_i    (update_s),
        .target_i    (duty_in),
        .duty_o      (duty_q_s),
        .duty_next_o (duty_next_s)
    );

    // Desired level is evaluated for the count and duty of the coming cycle,
    // so a registered gate change lands exactly on the compare boundary.
    always_comb begin
        duty_ext_s = {1'b0, duty_next_s};
        if (duty_ext_s <= DT_W) begin
            d_eff_s = {(CNT_WIDTH + 1){1'b0}};
        end else if (duty_ext_s >= HI_THR_W) begin
            d_eff_s = FULL_W;
        end else begin
            d_eff_s = duty_ext_s;
        end
        want_hi_s = ({1'b0, cnt_d_s} < d_eff_s);
    end

    // Gate sequencing FSM with registered gate, strobe and fault outputs.
    always_ff @(posedge c20k) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= {CNT_WIDTH{1'b0}};
            dead_q          <= {DW{1'b0}};
            gate_hi_q       <= 1'b0;
            gate_lo_q       <= 1'b0;
            period_start_q  <= 1'b0;
            fault_latched_q <= 1'b0;
        end else if (fault) begin
            state_q         <= FAULT;
            gate_hi_q       <= 1'b0;
            gate_lo_q       <= 1'b0;
            period_start_q  <= 1'b0;
            fault_latched_q <= 1'b1;
        end else if (!enable) begin
            // Also the FAULT exit: fault is low here, so the latch clears.
            state_q         <= IDLE;
            cnt_q           <= {CNT_WIDTH{1'b0}};
            gate_hi_q       <= 1'b0;
            gate_lo_q       <= 1'b0;
            period_start_q  <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            period_start_q <= wrap_s;
            cnt_q          <= cnt_d_s;
            case (state_q)
                IDLE: begin
                    gate_hi_q <= 1'b0;
                    gate_lo_q <= 1'b0;
                    if (!fault_latched_q) begin
                        state_q <= DEAD_LH;
                        dead_q  <= DEAD_LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN_HI: begin
                    gate_lo_q <= 1'b0;
                    if (!want_hi_s) begin
                        state_q   <= DEAD_HL;
                        dead_q    <= DEAD_LOAD;
                        gate_hi_q <= 1'b0;
                    end else begin
                        gate_hi_q <= 1'b1;
                    end
                end
                RUN_LO: begin
                    gate_hi_q <= 1'b0;
                    if (want_hi_s) begin
                        state_q   <= DEAD_LH;
                        dead_q    <= DEAD_LOAD;
                        gate_lo_q <= 1'b0;
                    end else begin
                        gate_lo_q <= 1'b1;
                    end
                end
                DEAD_HL, DEAD_LH: begin
                    // Either side may follow: no second dead interval when the
                    // level went back to where it came from.
                    if (dead_q == {DW{1'b0}}) begin
                        state_q   <= want_hi_s ? RUN_HI : RUN_LO;
                        gate_hi_q <= want_hi_s;
                        gate_lo_q <= !want_hi_s;
                    end else begin
                        dead_q    <= dead_q - DW'(1);
                        gate_hi_q <= 1'b0;
                        gate_lo_q <= 1'b0;
                    end
                end
                FAULT: begin
                    state_q   <= FAULT;
                    gate_hi_q <= 1'b0;
                    gate_lo_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    gate_hi_q <= 1'b0;
                    gate_lo_q <= 1'b0;
                end
            endcase
        end
    end

    assign gate_hi       = gate_hi_q;
    assign gate_lo       = gate_lo_q;
    assign period_start  = period_start_q;
    assign duty_applied  = duty_q_s;
    assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_motor_pwm_driver
// Scoreboard bench for motor_pwm_driver with an 8-bit counter (256-cycle
// period), DEADTIME 4 and SLEW_STEP 16. Each run phase pushes one expected
// record per wrap: the applied duty after the wrap and the gate_hi/gate_lo
// cycle counts of the period that just ended. The monitor pops a record on
// every period_start pulse.
// ---------------------------------------------------------------------------
module tb_motor_pwm_driver;

    localparam int CW   = 8;
    localparam int PER  = 256;
    localparam int DT   = 4;
    localparam int SLEW = 16;

    typedef struct {
        int duty;
        int hi;
        int lo;
    } exp_t;

    logic          c20k = 1'b0;
    logic          reset;
    logic          enable;
    logic          fault;
    logic [CW-1:0] duty_in;
    logic          gate_hi;
    logic          gate_lo;
    logic          period_start;
    logic [CW-1:0] duty_applied;
    logic          fault_latched;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   acc_hi   = 0;
    int   acc_lo   = 0;
    int   inv_err  = 0;
    int   dt_err   = 0;
    int   last_side = -1;
    int   gap      = 0;

    motor_pwm_driver #(
        .CNT_WIDTH (CW),
        .DEADTIME  (DT),
        .SLEW_STEP (SLEW)
    ) dut (
        .c20k          (c20k),
        .reset         (reset),
        .enable        (enable),
        .fault         (fault),
        .duty_in       (duty_in),
        .gate_hi       (gate_hi),
        .gate_lo       (gate_lo),
        .period_start  (period_start),
        .duty_applied  (duty_applied),
        .fault_latched (fault_latched)
    );

    always #5 c20k = ~c20k;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Expected records for a run started from IDLE (applied duty 0).
    // Target is tgt_a for wraps 1..n_a and tgt_b afterwards.
    task automatic push_run(input int n, input int tgt_a, input int n_a, input int tgt_b);
        int   app;
        int   d;
        int   tgt;
        bit   first;
        bit   prior_hi;
        exp_t e;
        app      = 0;
        first    = 1'b1;
        prior_hi = 1'b0;
        for (int k = 1; k <= n; k++) begin
            d = (app <= DT) ? 0 : ((app >= PER - DT) ? PER : app);
            if (first) begin
                e.hi = 0;
                e.lo = PER - DT;
            end else if (d == 0) begin
                e.hi = 0;
                e.lo = prior_hi ? PER - DT : PER;
            end else if (d == PER) begin
                e.hi = prior_hi ? PER : PER - DT;
                e.lo = 0;
            end else begin
                e.hi = prior_hi ? d : d - DT;
                e.lo = PER - DT - d;
            end
            first    = 1'b0;
            prior_hi = (d == PER);
            tgt = (k <= n_a) ? tgt_a : tgt_b;
            if (tgt > app) begin
                app = app + (((tgt - app) < SLEW) ? (tgt - app) : SLEW);
            end else begin
                app = app - (((app - tgt) < SLEW) ? (app - tgt) : SLEW);
            end
            e.duty = app;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: per-period scoreboard plus gate overlap / dead-time tracking.
    always @(negedge c20k) begin
        exp_t e;
        if (reset || !enable) begin
            acc_hi = 0;
            acc_lo = 0;
        end else if (period_start) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_period_start: got duty %0d expected no wrap", duty_applied);
            end else begin
                e = exp_q.pop_front();
                chk("wrap_duty_applied", int'(duty_applied), e.duty);
                chk("period_hi_cycles", acc_hi, e.hi);
                chk("period_lo_cycles", acc_lo, e.lo);
            end
            acc_hi = int'(gate_hi);
            acc_lo = int'(gate_lo);
        end else begin
            acc_hi = acc_hi + int'(gate_hi);
            acc_lo = acc_lo + int'(gate_lo);
        end
        if (gate_hi && gate_lo) inv_err++;
        if (gate_hi || gate_lo) begin
            if (last_side != -1 && last_side != int'(gate_hi) && gap < DT) dt_err++;
            last_side = int'(gate_hi);
            gap = 0;
        end else begin
            gap++;
        end
    end

    initial begin
        int bad;
        reset   = 1'b1;
        enable  = 1'b0;
        fault   = 1'b0;
        duty_in = 8'd0;
        repeat (3) @(negedge c20k);
        chk("reset_gate_hi", int'(gate_hi), 0);
        chk("reset_gate_lo", int'(gate_lo), 0);
        chk("reset_period_start", int'(period_start), 0);
        chk("reset_duty_applied", int'(duty_applied), 0);
        chk("reset_fault_latched", int'(fault_latched), 0);
        reset = 1'b0;
        repeat (2) @(negedge c20k);

        // Slew ramp 0 -> 200, then step down to 0.
        push_run(30, 200, 15, 0);
        duty_in = 8'd200;
        enable  = 1'b1;
        repeat (15 * PER + 128) @(negedge c20k);
        chk("ramp_top_duty", int'(duty_applied), 200);
        duty_in = 8'd0;
        repeat (15 * PER) @(negedge c20k);
        chk("ramp_records_left", exp_q.size(), 0);
        chk("ramp_bottom_duty", int'(duty_applied), 0);
        enable = 1'b0;
        @(negedge c20k);
        chk("disable_gate_hi", int'(gate_hi), 0);
        chk("disable_gate_lo", int'(gate_lo), 0);
        repeat (2) @(negedge c20k);

        // Fault at count 100 of period 9 while the high side is on.
        push_run(8, 200, 8, 200);
        duty_in = 8'd200;
        enable  = 1'b1;
        repeat (8 * PER + 101) @(negedge c20k);
        chk("prefault_gate_hi", int'(gate_hi), 1);
        chk("prefault_duty", int'(duty_applied), 128);
        fault = 1'b1;
        @(negedge c20k);
        fault = 1'b0;
        chk("fault_gate_hi", int'(gate_hi), 0);
        chk("fault_gate_lo", int'(gate_lo), 0);
        chk("fault_latched_set", int'(fault_latched), 1);
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge c20k);
            if (gate_hi || gate_lo || !fault_latched || period_start) bad++;
        end
        chk("fault_hold_violations", bad, 0);
        enable = 1'b0;
        repeat (2) @(negedge c20k);
        chk("fault_exit_latched", int'(fault_latched), 0);
        chk("fault_exit_duty", int'(duty_applied), 0);

        // Lower dead-band: duty 3 keeps the high side off; reset mid-period.
        push_run(3, 3, 3, 3);
        duty_in = 8'd3;
        enable  = 1'b1;
        repeat (3 * PER + 78) @(negedge c20k);
        chk("lowband_gate_lo", int'(gate_lo), 1);
        chk("lowband_gate_hi", int'(gate_hi), 0);
        chk("lowband_duty", int'(duty_applied), 3);
        reset = 1'b1;
        @(negedge c20k);
        chk("midreset_gate_hi", int'(gate_hi), 0);
        chk("midreset_gate_lo", int'(gate_lo), 0);
        chk("midreset_period_start", int'(period_start), 0);
        chk("midreset_duty", int'(duty_applied), 0);
        chk("midreset_fault_latched", int'(fault_latched), 0);
        reset  = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge c20k);
        chk("lowband_records_left", exp_q.size(), 0);

        // Restart after reset, ramp into the upper dead-band (full on).
        push_run(18, 254, 18, 254);
        duty_in = 8'd254;
        enable  = 1'b1;
        repeat (18 * PER + 128) @(negedge c20k);
        chk("fullon_gate_hi", int'(gate_hi), 1);
        chk("fullon_gate_lo", int'(gate_lo), 0);
        chk("fullon_duty", int'(duty_applied), 254);
        chk("fullon_records_left", exp_q.size(), 0);
        enable = 1'b0;
        repeat (2) @(negedge c20k);

        chk("gate_overlap_cycles", inv_err, 0);
        chk("short_deadtime_handovers", dt_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
